blinds_motor_sequencer: RTL

BLINDS_MOTOR_SEQUENCER -- requirements
Module: blinds_motor_sequencer

---
 rtl/blinds_pkg.sv | 30 +++
 rtl/light_hysteresis_filter.sv | 60 ++++++
 rtl/blinds_motor_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/blinds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blinds_pkg
// Description : Shared types and default constants for the blinds sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package blinds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    localparam int unsigned c_TRAVEL_CYCLES   = 100;
    localparam int unsigned c_DEAD_CYCLES     = 4;
    localparam int unsigned c_LIGHT_HI        = 150;
    localparam int unsigned c_LIGHT_LO        = 100;
    localparam int unsigned c_HOLD_CYCLES     = 8;
    localparam int unsigned c_OVERRIDE_CYCLES = 1000;

endpackage : blinds_pkg
`default_nettype wire

// File: rtl/light_hysteresis_filter.sv
`default_nettype none
// ============================================================================
// Module      : light_hysteresis_filter
// Description : Turns ambient light samples into one-shot auto open/close
//               requests after a run of consecutive bright or dark samples.
// Revision    : 1.0 - initial release
// ============================================================================
module light_hysteresis_filter
    import blinds_pkg::*;
#(
    parameter int unsigned LIGHT_HI    = c_LIGHT_HI,
    parameter int unsigned LIGHT_LO    = c_LIGHT_LO,
    parameter int unsigned HOLD_CYCLES = c_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] light_level,
    input  logic       hold_clear,
    output logic       auto_up,
    output logic       auto_down
);

    localparam int unsigned         c_CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_HOLD_MAX  = c_CNT_W'(HOLD_CYCLES);
    localparam logic [c_CNT_W-1:0]  c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_bright_cnt;
    logic [c_CNT_W-1:0] r_dark_cnt;
    logic               w_bright;
    logic               w_dark;

    assign w_bright = (light_level >= 8'(LIGHT_HI));
    assign w_dark   = (light_level <  8'(LIGHT_LO)) && !w_bright;

    // Counters saturate at HOLD so each qualifying run yields a single pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bright_cnt <= '0;
            r_dark_cnt   <= '0;
        end else if (hold_clear) begin
            r_bright_cnt <= '0;
            r_dark_cnt   <= '0;
        end else if (w_bright) begin
            r_bright_cnt <= (r_bright_cnt == c_HOLD_MAX) ? c_HOLD_MAX : r_bright_cnt + c_CNT_ONE;
            r_dark_cnt   <= '0;
        end else if (w_dark) begin
            r_dark_cnt   <= (r_dark_cnt == c_HOLD_MAX) ? c_HOLD_MAX : r_dark_cnt + c_CNT_ONE;
            r_bright_cnt <= '0;
        end else begin
            r_bright_cnt <= '0;
            r_dark_cnt   <= '0;
        end
    end

    assign auto_up   = !hold_clear && w_bright && (r_bright_cnt == c_HOLD_LAST);
    assign auto_down = !hold_clear && w_dark   && (r_dark_cnt   == c_HOLD_LAST);

endmodule : light_hysteresis_filter
`default_nettype wire

// File: rtl/blinds_motor_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : blinds_motor_sequencer
// Description : Blinds motor controller with manual/auto arbitration, travel
//               tracking and a dead-time interlock on direction reversal.
// Revision    : 1.0 - initial release
// ============================================================================
module blinds_motor_sequencer
    import blinds_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES   = c_TRAVEL_CYCLES,
    parameter int unsigned DEAD_CYCLES     = c_DEAD_CYCLES,
    parameter int unsigned LIGHT_HI        = c_LIGHT_HI,
    parameter int unsigned LIGHT_LO        = c_LIGHT_LO,
    parameter int unsigned HOLD_CYCLES     = c_HOLD_CYCLES,
    parameter int unsigned OVERRIDE_CYCLES = c_OVERRIDE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] light_level,
    input  logic       open_signal,
    input  logic       close_signal,
    output logic       motor_up,
    output logic       motor_down,
    output logic [7:0] position,
    output logic       blinds_open,
    output logic       blinds_closed
);

    localparam int unsigned          c_DEAD_W      = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int unsigned          c_OVR_W       = $clog2(OVERRIDE_CYCLES + 2);
    localparam logic [7:0]           c_TRAVEL      = 8'(TRAVEL_CYCLES);
    localparam logic [7:0]           c_TRAVEL_LAST = 8'(TRAVEL_CYCLES - 1);
    localparam logic [c_DEAD_W-1:0]  c_DEAD_LAST   = c_DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [c_DEAD_W-1:0]  c_DEAD_ONE    = c_DEAD_W'(1);
    localparam logic [c_OVR_W-1:0]   c_OVR_LOAD    = c_OVR_W'(OVERRIDE_CYCLES);
    localparam logic [c_OVR_W-1:0]   c_OVR_ONE     = c_OVR_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    dir_t                r_pending;
    dir_t                w_pending_nxt;
    dir_t                w_req;
    dir_t                w_dead_dir;
    logic [7:0]          r_position;
    logic [7:0]          w_position_nxt;
    logic [c_DEAD_W-1:0] r_dead_cnt;
    logic [c_DEAD_W-1:0] w_dead_cnt_nxt;
    logic [c_OVR_W-1:0]  r_override;
    logic                r_motor_up;
    logic                r_motor_down;
    logic                w_motor_up_nxt;
    logic                w_motor_down_nxt;
    logic                w_manual;
    logic                w_hold_clear;
    logic                w_auto_up;
    logic                w_auto_down;

    assign w_manual     = open_signal | close_signal;
    assign w_hold_clear = w_manual || (r_override != '0);

    // Manual commands suppress auto requests for OVERRIDE_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_override <= '0;
        end else if (w_manual) begin
            r_override <= c_OVR_LOAD;
        end else if (r_override != '0) begin
            r_override <= r_override - c_OVR_ONE;
        end
    end

    light_hysteresis_filter #(
        .LIGHT_HI    (LIGHT_HI),
        .LIGHT_LO    (LIGHT_LO),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_light_filter (
        .clk         (clk),
        .rst         (rst),
        .light_level (light_level),
        .hold_clear  (w_hold_clear),
        .auto_up     (w_auto_up),
        .auto_down   (w_auto_down)
    );

    always_comb begin
        w_req = DIR_NONE;
        if (close_signal) begin
            w_req = DIR_DOWN;
        end else if (open_signal) begin
            w_req = DIR_UP;
        end else if (w_auto_down) begin
            w_req = DIR_DOWN;
        end else if (w_auto_up) begin
            w_req = DIR_UP;
        end
    end

    // A request arriving on the last dead cycle still overrides the pending one.
    assign w_dead_dir = (w_req != DIR_NONE) ? w_req : r_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pending    <= DIR_NONE;
            r_position   <= '0;
            r_dead_cnt   <= '0;
            r_motor_up   <= 1'b0;
            r_motor_down <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pending    <= w_pending_nxt;
            r_position   <= w_position_nxt;
            r_dead_cnt   <= w_dead_cnt_nxt;
            r_motor_up   <= w_motor_up_nxt;
            r_motor_down <= w_motor_down_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_position_nxt = r_position;
        w_dead_cnt_nxt = r_dead_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req == DIR_UP && r_position < c_TRAVEL) begin
                    w_state_nxt = ST_UP;
                end else if (w_req == DIR_DOWN && r_position != '0) begin
                    w_state_nxt = ST_DOWN;
                end
            end
            ST_UP: begin
                if (w_req == DIR_DOWN) begin
                    w_state_nxt    = ST_DEAD;
                    w_pending_nxt  = DIR_DOWN;
                    w_dead_cnt_nxt = '0;
                end else if (r_position >= c_TRAVEL_LAST) begin
                    w_state_nxt    = ST_IDLE;
                    w_position_nxt = c_TRAVEL;
                end else begin
                    w_position_nxt = r_position + 8'd1;
                end
            end
            ST_DOWN: begin
                if (w_req == DIR_UP) begin
                    w_state_nxt    = ST_DEAD;
                    w_pending_nxt  = DIR_UP;
                    w_dead_cnt_nxt = '0;
                end else if (r_position <= 8'd1) begin
                    w_state_nxt    = ST_IDLE;
                    w_position_nxt = '0;
                end else begin
                    w_position_nxt = r_position - 8'd1;
                end
            end
            ST_DEAD: begin
                w_pending_nxt = w_dead_dir;
                if (r_dead_cnt == c_DEAD_LAST) begin
                    w_pending_nxt  = DIR_NONE;
                    w_dead_cnt_nxt = '0;
                    if (w_dead_dir == DIR_UP && r_position < c_TRAVEL) begin
                        w_state_nxt = ST_UP;
                    end else if (w_dead_dir == DIR_DOWN && r_position != '0) begin
                        w_state_nxt = ST_DOWN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_dead_cnt_nxt = r_dead_cnt + c_DEAD_ONE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pending_nxt = DIR_NONE;
            end
        endcase
    end

    always_comb begin
        w_motor_up_nxt   = (w_state_nxt == ST_UP);
        w_motor_down_nxt = (w_state_nxt == ST_DOWN);
    end

    assign motor_up      = r_motor_up;
    assign motor_down    = r_motor_down;
    assign position      = r_position;
    assign blinds_open   = (r_state == ST_IDLE) && (r_position == c_TRAVEL);
    assign blinds_closed = (r_state == ST_IDLE) && (r_position == '0);

endmodule : blinds_motor_sequencer
`default_nettype wire
